// File: rtl/read_checker_if.sv
// Read-request / read-data / result bundle between the read driver, the memory under test
// and the read checker.
interface read_checker_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              i_RD_EN;
  logic [ADDR_W-1:0] i_RD_ADDR;
  logic              i_RD_LAST;
  logic [DATA_W-1:0] i_RD_DATA;
  logic              o_MISMATCH;
  logic [CNT_W-1:0]  o_ERR_CNT;
  logic [ADDR_W-1:0] o_FAIL_ADDR;
  logic              o_FAIL_VLD;
  logic              o_DONE;
  logic              o_PASS;

  modport master (
    output i_RD_EN, i_RD_ADDR, i_RD_LAST, i_RD_DATA,
    input  o_MISMATCH, o_ERR_CNT, o_FAIL_ADDR, o_FAIL_VLD, o_DONE, o_PASS
  );

  modport slave (
    input  i_RD_EN, i_RD_ADDR, i_RD_LAST, i_RD_DATA,
    output o_MISMATCH, o_ERR_CNT, o_FAIL_ADDR, o_FAIL_VLD, o_DONE, o_PASS
  );
endinterface

// File: rtl/read_checker.sv
// Tracks read requests through the memory read latency and compares returned data with
// ADDR ^ SEED, reporting mismatch pulses, a saturating error count, first failing address and PASS/DONE.
module read_checker #(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       RD_LAT = 2,
  parameter logic [DATA_W-1:0] SEED   = 8'hA5,
  parameter int unsigned       CNT_W  = 8
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  read_checker_if.slave rd_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e state_q, state_d;

  logic [RD_LAT-1:0]             vld_q;
  logic [RD_LAT-1:0]             last_q;
  logic [RD_LAT-1:0][ADDR_W-1:0] addr_q;

  logic              mismatch_q, mismatch_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_vld_q, fail_vld_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic              accept;
  logic              cmp_vld;
  logic              cmp_last;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] addr_ext;
  logic              cmp_err;

  assign accept   = (state_q != S_DONE);
  // Gating with accept discards requests still in flight behind the final one.
  assign cmp_vld  = vld_q[RD_LAT-1] & accept;
  assign cmp_last = last_q[RD_LAT-1];
  assign cmp_addr = addr_q[RD_LAT-1];

  if (ADDR_W >= DATA_W) begin : g_trunc
    assign addr_ext = cmp_addr[DATA_W-1:0];
  end else begin : g_zext
    assign addr_ext = {{(DATA_W-ADDR_W){1'b0}}, cmp_addr};
  end

  assign cmp_err = (rd_if.i_RD_DATA != (addr_ext ^ SEED));

  always_comb begin
    state_d     = state_q;
    mismatch_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_vld_d  = fail_vld_q;
    done_d      = done_q;

    case (state_q)
      S_IDLE: if (rd_if.i_RD_EN) state_d = S_RUN;
      S_RUN: begin
        if (cmp_vld && cmp_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (cmp_vld && cmp_err) begin
      mismatch_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (!fail_vld_q) begin
        fail_addr_d = cmp_addr;
        fail_vld_d  = 1'b1;
      end
    end

    pass_d = done_d & (err_cnt_d == '0);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= S_IDLE;
      vld_q       <= '0;
      last_q      <= '0;
      addr_q      <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      vld_q[0]  <= rd_if.i_RD_EN & accept;
      last_q[0] <= rd_if.i_RD_LAST;
      addr_q[0] <= rd_if.i_RD_ADDR;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
      state_q     <= state_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_vld_q  <= fail_vld_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign rd_if.o_MISMATCH  = mismatch_q;
  assign rd_if.o_ERR_CNT   = err_cnt_q;
  assign rd_if.o_FAIL_ADDR = fail_addr_q;
  assign rd_if.o_FAIL_VLD  = fail_vld_q;
  assign rd_if.o_DONE      = done_q;
  assign rd_if.o_PASS      = pass_q;

endmodule
